// File: rtl/sha_padder_pkg.sv
// Shared constants and bus views for the SHA message padder.
package sha_padder_pkg;

  localparam int unsigned SHA256_BLK_BITS = 512;
  localparam int unsigned SHA256_LEN_BITS = 64;
  localparam int unsigned SHA512_BLK_BITS = 1024;
  localparam int unsigned SHA512_LEN_BITS = 128;
  localparam int unsigned SHA_IN_BYTES    = 4;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Extra block still owed after the current one is taken
  localparam logic [1:0] PAD_NONE     = 2'd0;
  localparam logic [1:0] PAD_LEN      = 2'd1;
  localparam logic [1:0] PAD_MARK_LEN = 2'd2;

  typedef struct packed {
    logic [8*SHA_IN_BYTES-1:0]         data;
    logic                              valid;
    logic                              last;
    logic [$clog2(SHA_IN_BYTES+1)-1:0] nbytes;
  } sha_pad_in_type;

  typedef struct packed {
    logic [SHA256_BLK_BITS-1:0] data;
    logic                       valid;
    logic                       first;
    logic                       last;
  } sha_pad_out_type;

endpackage

// File: rtl/sha_padder.sv
// Streaming byte-message padder: packs input beats into blocks and appends
// the 0x80 marker, zero fill and big-endian bit length.
module sha_padder
  import sha_padder_pkg::*;
#(
  parameter int unsigned IN_BYTES = SHA_IN_BYTES,
  parameter int unsigned BLK_BITS = SHA256_BLK_BITS,
  parameter int unsigned LEN_BITS = SHA256_LEN_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [8*IN_BYTES-1:0]            in_data,
  input  logic                             in_last,
  input  logic [$clog2(IN_BYTES+1)-1:0]    in_nbytes,
  output logic                             blk_valid,
  input  logic                             blk_ready,
  output logic [BLK_BITS-1:0]              blk_data,
  output logic                             blk_first,
  output logic                             blk_last
);

  localparam int unsigned BLK_BYTES = BLK_BITS / 8;
  localparam int unsigned LEN_BYTES = LEN_BITS / 8;
  localparam int unsigned NB_W      = $clog2(IN_BYTES + 1);
  localparam int unsigned POS_W     = $clog2(BLK_BYTES + 1);
  localparam int unsigned CNT_W     = LEN_BITS - 3;

  logic [0:0]          state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          pend_q, pend_d;
  logic [BLK_BITS-1:0] data_d;
  logic                valid_d, first_d, last_d, ready_d;

  logic [NB_W-1:0]     n_eff;
  logic [POS_W-1:0]    pos_end, pos_full;
  logic [CNT_W-1:0]    cnt_end;
  logic                len_fits;

  // Copy beat bytes to lanes pos..pos+n-1; on a last beat also place the marker and zero the rest
  function automatic logic [BLK_BITS-1:0] write_lanes(
    input logic [BLK_BITS-1:0]   b,
    input logic [8*IN_BYTES-1:0] d,
    input int                    pos,
    input int                    n,
    input logic                  last
  );
    logic [BLK_BITS-1:0] r;
    r = b;
    for (int j = 0; j < int'(BLK_BYTES); j++) begin
      if (j >= pos && j < pos + n)
        r[BLK_BITS-1-8*j -: 8] = d[8*IN_BYTES-1-8*(j-pos) -: 8];
      else if (last && j == pos + n)
        r[BLK_BITS-1-8*j -: 8] = PAD_BYTE;
      else if (last && j > pos + n)
        r[BLK_BITS-1-8*j -: 8] = 8'h00;
    end
    return r;
  endfunction

  function automatic logic [BLK_BITS-1:0] insert_len(
    input logic [BLK_BITS-1:0] b,
    input logic [LEN_BITS-1:0] len
  );
    logic [BLK_BITS-1:0] r;
    r = b;
    r[LEN_BITS-1:0] = len;
    return r;
  endfunction

  always_comb begin
    n_eff = NB_W'(IN_BYTES);
    if (in_last && in_nbytes <= NB_W'(IN_BYTES))
      n_eff = in_nbytes;
  end

  assign pos_end  = pos_q + POS_W'(n_eff);
  assign pos_full = pos_q + POS_W'(IN_BYTES);
  assign cnt_end  = cnt_q + CNT_W'(n_eff);
  assign len_fits = (32'(pos_end) + 32'd1) <= 32'(BLK_BYTES - LEN_BYTES);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      pos_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= PAD_NONE;
      blk_data  <= '0;
      blk_valid <= 1'b0;
      blk_first <= 1'b1;
      blk_last  <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      blk_data  <= data_d;
      blk_valid <= valid_d;
      blk_first <= first_d;
      blk_last  <= last_d;
      in_ready  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    data_d  = blk_data;
    valid_d = blk_valid;
    first_d = blk_first;
    last_d  = blk_last;
    ready_d = in_ready;

    case (state_q)
      ST_FILL: begin
        ready_d = 1'b1;
        if (in_valid && in_ready) begin
          cnt_d = cnt_end;
          if (!in_last) begin
            data_d = write_lanes(blk_data, in_data, int'(pos_q), int'(IN_BYTES), 1'b0);
            pos_d  = pos_full;
            if (pos_full == POS_W'(BLK_BYTES)) begin
              state_d = ST_EMIT;
              pos_d   = '0;
              last_d  = 1'b0;
              valid_d = 1'b1;
              ready_d = 1'b0;
            end
          end else begin
            data_d  = write_lanes(blk_data, in_data, int'(pos_q), int'(n_eff), 1'b1);
            state_d = ST_EMIT;
            pos_d   = '0;
            valid_d = 1'b1;
            ready_d = 1'b0;
            if (len_fits) begin
              data_d = insert_len(data_d, {cnt_end, 3'b000});
              last_d = 1'b1;
              pend_d = PAD_NONE;
            end else if (pos_end < POS_W'(BLK_BYTES)) begin
              last_d = 1'b0;
              pend_d = PAD_LEN;
            end else begin
              last_d = 1'b0;
              pend_d = PAD_MARK_LEN;
            end
          end
        end
      end

      default: begin
        ready_d = 1'b0;
        if (blk_ready) begin
          first_d = 1'b0;
          if (pend_q != PAD_NONE) begin
            // Trailing block: zeros, optional marker at byte 0, length in the tail
            data_d = '0;
            if (pend_q == PAD_MARK_LEN)
              data_d[BLK_BITS-1 -: 8] = PAD_BYTE;
            data_d = insert_len(data_d, {cnt_q, 3'b000});
            last_d = 1'b1;
            pend_d = PAD_NONE;
          end else begin
            if (blk_last) begin
              cnt_d   = '0;
              first_d = 1'b1;
            end
            state_d = ST_FILL;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: doc/sha_padder.md
Name: sha_padder

Overview:
Streaming message padder/blocker for the SHA cores. It accepts a byte-oriented message stream over a valid/ready interface and emits complete, FIPS 180-4 padded message blocks: 0x80 terminator, zero fill and big-endian bit-length field. It is parametrised for SHA-256 (512-bit block, 64-bit length) or SHA-512 (1024-bit block, 128-bit length). It sits between the host/data source and the sha compression core, replacing bench-side file-driven block building.

Parameters:
IN_BYTES, 4, bytes per input beat; BLK_BYTES % IN_BYTES == 0 required
BLK_BITS, 512, message block width (512 or 1024)
LEN_BITS, 64, length field width (64 for 512-bit blocks, 128 for 1024-bit blocks)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  padder accepts beat
in_data  in  8*IN_BYTES  message bytes, byte 0 in MSBs (big-endian)
in_last  in  1  final beat of message
in_nbytes  in  $clog2(IN_BYTES+1)  valid bytes in the last beat (0..IN_BYTES); ignored when in_last=0 (beat counts as full)
blk_valid  out  1  block available
blk_ready  in  1  consumer takes block
blk_data  out  BLK_BITS  padded block, byte 0 in MSBs
blk_first  out  1  block is first of its message
blk_last  out  1  block carries length field (final block)

Behaviour:
- Reset (rst=0 at posedge clk): state=FILL, pos=0, msg byte count=0, buffer cleared, in_ready=0 during reset then 1; blk_valid=0, blk_data=0, blk_first=1 (internal first flag), blk_last=0.
- BLK_BYTES=BLK_BITS/8, LEN_BYTES=LEN_BITS/8. Bit length = 8*byte count, kept modulo 2^LEN_BITS (wraps, no error).
- State FILL: in_ready=1. On a handshake, bytes are written at buffer[pos..]; pos and count advance by IN_BYTES, or by in_nbytes when in_last=1.
  - Non-last beat that makes pos==BLK_BYTES -> EMIT (blk_last=0), pos=0.
  - Last beat: write 0x80 at pos'=pos+n and zero bytes pos'+1..end.
    - If pos'+1 <= BLK_BYTES-LEN_BYTES: length is written into the final LEN_BYTES -> EMIT (blk_last=1).
    - Else if pos' < BLK_BYTES: -> EMIT (blk_last=0) with pad_pending=len_only.
    - Else (pos'==BLK_BYTES, block exactly full): no 0x80 written -> EMIT (blk_last=0) with pad_pending=marker_and_len.
- State EMIT: blk_valid=1, in_ready=0. blk_data, blk_first and blk_last are held stable until blk_ready=1. On the handshake:
  - blk_first is cleared.
  - If pad_pending, the buffer is rebuilt as all zero, plus 0x80 at byte 0 if marker_and_len, plus the length in the tail -> EMIT (blk_last=1), pad_pending cleared.
  - Else if blk_last: count=0, first flag set -> FILL.
  - Else -> FILL.
- Latency: a block is valid the cycle after the beat that completes it. The extra pad block is valid the cycle after the preceding block's handshake. No combinational path exists from blk_ready to in_ready.
- Throughput: a new block can start filling the cycle after blk handshake; in_ready never overlaps blk_valid.
- Reset mid-message or mid-EMIT drops all partial state; the next message starts with blk_first=1.
- in_nbytes>IN_BYTES on a last beat is clamped to IN_BYTES.

Decomposition:
- sha_const: BLK_BITS/LEN_BITS pairs for SHA-256 and SHA-512, PAD_BYTE=8'h80.
- sha_wire: sha_pad_in_type {data, valid, last, nbytes} and sha_pad_out_type {data, valid, first, last}.
- Single module. Byte-lane write and length insertion are combinational functions inside it; no sub-module.

Test Plan:
- "abc" (IN_BYTES=4, 512/64): beat 0x61626300, nbytes=3, last -> one block 0x61626380, 0..0, tail 64'h18; first=1, last=1.
- Empty message: in_nbytes=0, last -> block 0x80 followed by zeros, length 0; first=1, last=1.
- 56-byte message -> block 1 holds data plus 0x80 at byte 56 with zeros, last=0; block 2 is all zero with tail 64'h1C0, first=0, last=1.
- 64-byte message -> block 1 is data only; block 2 has 0x80 at byte 0 and tail 64'h200.
- Backpressure: hold blk_ready=0 for 5 cycles -> blk_data stable, in_ready=0; assert reset mid-stream, then send "abc" -> correct single block with first=1.
- SHA-512 params (1024/128) with "abc" -> 0x61626380, zeros, 128-bit tail 0x18; a 112-byte message produces two blocks, the second with tail 0x380.
